// File: rtl/fp_minmax_cmp_pipe_if.sv
// Handshake/data bundle for fp_minmax_cmp_pipe: issue side (a, b, op) and result side.
// The master drives operands and out_ready; the slave is the min/max/compare unit.
interface fp_minmax_cmp_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         invalid;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, invalid
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, invalid
  );
endinterface

// File: rtl/fp_minmax_cmp_pipe.sv
// Two-stage FMIN/FMAX/FEQ/FLT/FLE unit with valid/ready backpressure.
// Optional accumulator ops (FMINACC/FMAXACC/ACCCLR) when FP_MINMAX_REDUCE_EN is defined.
module fp_minmax_cmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  fp_minmax_cmp_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] OP_FMIN    = 3'b000;
  localparam logic [2:0] OP_FMAX    = 3'b001;
  localparam logic [2:0] OP_FEQ     = 3'b010;
  localparam logic [2:0] OP_FLT     = 3'b011;
  localparam logic [2:0] OP_FLE     = 3'b100;
`ifdef FP_MINMAX_REDUCE_EN
  localparam logic [2:0] OP_FMINACC = 3'b101;
  localparam logic [2:0] OP_FMAXACC = 3'b110;
  localparam logic [2:0] OP_ACCCLR  = 3'b111;
`endif

  typedef struct packed {
    logic sign;
    logic zero;
    logic snan;
    logic qnan;
  } cls_t;

  function automatic cls_t classify(input logic [W-1:0] x);
    cls_t c;
    logic exp_ones;
    exp_ones = &x[W-2 -: EXP_W];
    c.sign = x[W-1];
    c.zero = ~|x[W-2:0];
    c.snan = exp_ones && (|x[MAN_W-1:0]) && !x[MAN_W-1];
    c.qnan = exp_ones && x[MAN_W-1];
    return c;
  endfunction

  // Raw sign-magnitude x < y; distinguishes -0 < +0.
  function automatic logic mag_lt(input logic sx, input logic [W-2:0] mx,
                                  input logic sy, input logic [W-2:0] my);
    if (sx != sy)
      return sx;
    else if (sx)
      return mx > my;
    else
      return mx < my;
  endfunction

  // Pipeline control
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv       = !s2_valid_reg || bus.out_ready;
  assign s1_adv       = s2_adv;
  assign bus.in_ready = !rst && (!s1_valid_reg || s1_adv);

  // Stage 1: operand capture and classification
  logic [W-1:0] in_opnd [2];
  cls_t         in_cls  [2];
  assign in_opnd[0] = bus.a;
  assign in_opnd[1] = bus.b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      assign in_cls[gi] = classify(in_opnd[gi]);
    end
  endgenerate

  logic [W-1:0] s1_a_reg;
  logic [W-1:0] s1_b_reg;
  logic [2:0]   s1_op_reg;
  cls_t         s1_ca_reg;
  cls_t         s1_cb_reg;

  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      s1_a_reg  <= bus.a;
      s1_b_reg  <= bus.b;
      s1_op_reg <= bus.op;
      s1_ca_reg <= in_cls[0];
      s1_cb_reg <= in_cls[1];
    end
  end

  // Stage 2 combinational compare/select
  logic [W-1:0] result_reg;
  logic         invalid_reg;
  logic [W-1:0] opb;
  cls_t         cb;
  logic         a_nan, b_nan, any_snan, both_zero, bits_eq;
  logic         a_lt_b, b_lt_a, is_max;
  logic [W-1:0] mm_res;
  logic [W-1:0] res_next;
  logic         inv_next;

`ifdef FP_MINMAX_REDUCE_EN
  logic [W-1:0] acc_reg;
  logic         s2_acc_reg;
  logic [W-1:0] acc_fwd;
  logic         s1_is_acc;
  // S1 only moves into S2 while S2 is leaving, so a pending accumulate result is forwarded.
  assign acc_fwd   = (s2_valid_reg && s2_acc_reg) ? result_reg : acc_reg;
  assign s1_is_acc = (s1_op_reg == OP_FMINACC) || (s1_op_reg == OP_FMAXACC) ||
                     (s1_op_reg == OP_ACCCLR);
`endif

  always_comb begin
    opb = s1_b_reg;
    cb  = s1_cb_reg;
    is_max = (s1_op_reg == OP_FMAX);
`ifdef FP_MINMAX_REDUCE_EN
    if (s1_op_reg == OP_FMINACC || s1_op_reg == OP_FMAXACC) begin
      opb = acc_fwd;
      cb  = classify(acc_fwd);
    end
    if (s1_op_reg == OP_FMAXACC)
      is_max = 1'b1;
`endif
    a_nan     = s1_ca_reg.snan || s1_ca_reg.qnan;
    b_nan     = cb.snan || cb.qnan;
    any_snan  = s1_ca_reg.snan || cb.snan;
    both_zero = s1_ca_reg.zero && cb.zero;
    bits_eq   = (s1_a_reg == opb);
    a_lt_b    = mag_lt(s1_ca_reg.sign, s1_a_reg[W-2:0], cb.sign, opb[W-2:0]);
    b_lt_a    = mag_lt(cb.sign, opb[W-2:0], s1_ca_reg.sign, s1_a_reg[W-2:0]);

    if (a_nan && b_nan)
      mm_res = CANON_NAN;
    else if (a_nan)
      mm_res = opb;
    else if (b_nan)
      mm_res = s1_a_reg;
    else if (is_max ? a_lt_b : b_lt_a)
      mm_res = opb;
    else
      mm_res = s1_a_reg;

    res_next = '0;
    inv_next = 1'b0;
    case (s1_op_reg)
      OP_FMIN, OP_FMAX: begin
        res_next = mm_res;
        inv_next = any_snan;
      end
      OP_FEQ: begin
        res_next[0] = !a_nan && !b_nan && (both_zero || bits_eq);
        inv_next    = any_snan;
      end
      OP_FLT: begin
        res_next[0] = !a_nan && !b_nan && !both_zero && a_lt_b;
        inv_next    = a_nan || b_nan;
      end
      OP_FLE: begin
        res_next[0] = !a_nan && !b_nan && (both_zero || bits_eq || a_lt_b);
        inv_next    = a_nan || b_nan;
      end
`ifdef FP_MINMAX_REDUCE_EN
      OP_FMINACC, OP_FMAXACC: begin
        res_next = mm_res;
        inv_next = any_snan;
      end
      OP_ACCCLR: begin
        res_next = CANON_NAN;
        inv_next = 1'b0;
      end
`endif
      default: begin
        res_next = '0;
        inv_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      result_reg   <= '0;
      invalid_reg  <= 1'b0;
    end else begin
      if (bus.in_ready)
        s1_valid_reg <= bus.in_valid;
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          result_reg  <= res_next;
          invalid_reg <= inv_next;
        end
      end
    end
  end

`ifdef FP_MINMAX_REDUCE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= CANON_NAN;
      s2_acc_reg <= 1'b0;
    end else begin
      if (s2_valid_reg && bus.out_ready && s2_acc_reg)
        acc_reg <= result_reg;
      if (s2_adv && s1_valid_reg)
        s2_acc_reg <= s1_is_acc;
    end
  end
`endif

  assign bus.out_valid = s2_valid_reg;
  assign bus.result    = result_reg;
  assign bus.invalid   = invalid_reg;
endmodule
